// File: rtl/calc1_defs.sv
// Shared command, response and state encodings for the calc1 requester.
package calc1_defs;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP1  = 3'd1,
    ST_OP2  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/calc1_timeout_ctr.sv
// Response timeout counter: clear, count-enable, and a flag raised on the
// enabled cycle whose increment reaches TIMEOUT_CYCLES.
module calc1_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 10,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == TC_LAST);

endmodule

// File: rtl/calc1_req_driver.sv
// Requester for one calc1 port: accepts a host operation, serialises it as
// cmd/op1 then op2, waits for a response or timeout, and hands the result back.
module calc1_req_driver
  import calc1_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [0:3]       host_cmd,
  input  logic [0:31]      host_op1,
  input  logic [0:31]      host_op2,
  output logic [0:3]       req_cmd_out,
  output logic [0:31]      req_data_out,
  input  logic [0:1]       in_resp,
  input  logic [0:31]      in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [0:1]       res_resp,
  output logic [0:31]      res_data,
  output logic             res_timeout,
  output logic             stray_resp,
  output logic [0:CNT_W-1] txn_count
);

  state_e           state_d,       state_q;
  logic             host_ready_d,  host_ready_q;
  logic [0:31]      op2_d,         op2_q;
  logic [0:3]       req_cmd_d,     req_cmd_q;
  logic [0:31]      req_data_d,    req_data_q;
  logic             res_valid_d,   res_valid_q;
  logic [0:1]       res_resp_d,    res_resp_q;
  logic [0:31]      res_data_d,    res_data_q;
  logic             res_timeout_d, res_timeout_q;
  logic             stray_d,       stray_q;
  logic [0:CNT_W-1] txn_d,         txn_q;
  logic             ctr_clr_s;
  logic             ctr_en_s;
  logic             ctr_tc_s;

  calc1_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout_ctr (
    .clk   (c_clk),
    .reset (reset),
    .clr   (ctr_clr_s),
    .en    (ctr_en_s),
    .tc    (ctr_tc_s)
  );

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    state_d       = state_q;
    host_ready_d  = host_ready_q;
    op2_d         = op2_q;
    req_cmd_d     = req_cmd_q;
    req_data_d    = req_data_q;
    res_valid_d   = res_valid_q;
    res_resp_d    = res_resp_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    txn_d         = txn_q;
    ctr_clr_s     = 1'b0;
    ctr_en_s      = 1'b0;
    // A response is only legitimate while waiting; anything else is flagged, never captured.
    stray_d       = stray_q | ((in_resp != 2'd0) && (state_q != ST_WAIT));

    case (state_q)
      ST_IDLE: begin
        host_ready_d = 1'b1;
        if (host_valid && host_ready_q) begin
          host_ready_d = 1'b0;
          op2_d        = host_op2;
          if (host_cmd == CMD_NOP) begin
            state_d       = ST_DONE;
            res_valid_d   = 1'b1;
            res_resp_d    = RESP_ERR;
            res_data_d    = 32'd0;
            res_timeout_d = 1'b0;
          end else begin
            state_d    = ST_OP1;
            req_cmd_d  = host_cmd;
            req_data_d = host_op1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OP1: begin
        state_d    = ST_OP2;
        req_cmd_d  = 4'd0;
        req_data_d = op2_q;
      end
      ST_OP2: begin
        state_d    = ST_WAIT;
        req_cmd_d  = 4'd0;
        req_data_d = 32'd0;
        ctr_clr_s  = 1'b1;
      end
      ST_WAIT: begin
        if (in_resp != RESP_NONE) begin
          state_d       = ST_DONE;
          res_valid_d   = 1'b1;
          res_resp_d    = in_resp;
          res_data_d    = in_data;
          res_timeout_d = 1'b0;
        end else begin
          ctr_en_s = 1'b1;
          if (ctr_tc_s) begin
            state_d       = ST_DONE;
            res_valid_d   = 1'b1;
            res_resp_d    = RESP_NONE;
            res_data_d    = 32'd0;
            res_timeout_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d       = ST_IDLE;
          host_ready_d  = 1'b1;
          res_valid_d   = 1'b0;
          res_resp_d    = 2'd0;
          res_data_d    = 32'd0;
          res_timeout_d = 1'b0;
          txn_d         = txn_q + CNT_W'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        host_ready_d  = 1'b0;
        req_cmd_d     = 4'd0;
        req_data_d    = 32'd0;
        res_valid_d   = 1'b0;
        res_resp_d    = 2'd0;
        res_data_d    = 32'd0;
        res_timeout_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      host_ready_q  <= 1'b0;
      op2_q         <= 32'd0;
      req_cmd_q     <= 4'd0;
      req_data_q    <= 32'd0;
      res_valid_q   <= 1'b0;
      res_resp_q    <= 2'd0;
      res_data_q    <= 32'd0;
      res_timeout_q <= 1'b0;
      stray_q       <= 1'b0;
      txn_q         <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      host_ready_q  <= host_ready_d;
      op2_q         <= op2_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      res_valid_q   <= res_valid_d;
      res_resp_q    <= res_resp_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      stray_q       <= stray_d;
      txn_q         <= txn_d;
    end
  end

  assign host_ready   = host_ready_q;
  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign res_valid    = res_valid_q;
  assign res_resp     = res_resp_q;
  assign res_data     = res_data_q;
  assign res_timeout  = res_timeout_q;
  assign stray_resp   = stray_q;
  assign txn_count    = txn_q;

endmodule

// File: tb/tb_calc1_req_driver.sv
// Directed bench for calc1_req_driver with hand-computed expectations.
module tb_calc1_req_driver;
  import calc1_defs::*;

  logic        c_clk;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [0:3]  host_cmd;
  logic [0:31] host_op1;
  logic [0:31] host_op2;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  in_resp;
  logic [0:31] in_data;
  logic        res_valid;
  logic        res_ready;
  logic [0:1]  res_resp;
  logic [0:31] res_data;
  logic        res_timeout;
  logic        stray_resp;
  logic [0:7]  txn_count;

  int checks = 0;
  int errors = 0;

  calc1_req_driver #(
    .TIMEOUT_CYCLES (10),
    .CNT_W          (8)
  ) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_cmd     (host_cmd),
    .host_op1     (host_op1),
    .host_op2     (host_op2),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .in_resp      (in_resp),
    .in_data      (in_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_resp     (res_resp),
    .res_data     (res_data),
    .res_timeout  (res_timeout),
    .stray_resp   (stray_resp),
    .txn_count    (txn_count)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // Offer one operation in IDLE; returns in the first WAIT cycle.
  task automatic send(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_op1   = op1;
    host_op2   = op2;
    tick();
    host_valid = 1'b0;
    host_cmd   = 4'd0;
    host_op1   = 32'd0;
    host_op2   = 32'd0;
    chk("op1_cmd", req_cmd_out, cmd);
    chk("op1_data", req_data_out, op1);
    chk("op1_host_ready", host_ready, 1'b0);
    tick();
    chk("op2_cmd", req_cmd_out, 4'd0);
    chk("op2_data", req_data_out, op2);
    tick();
    chk("wait_bus", {req_cmd_out, req_data_out}, 36'd0);
    chk("wait_res_valid", res_valid, 1'b0);
  endtask

  task automatic respond(input logic [1:0] resp, input logic [31:0] data);
    in_resp = resp;
    in_data = data;
    tick();
    in_resp = 2'd0;
    in_data = 32'd0;
  endtask

  task automatic ack(input logic [7:0] exp_txn);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("ack_res_valid", res_valid, 1'b0);
    chk("ack_host_ready", host_ready, 1'b1);
    chk("ack_txn", txn_count, exp_txn);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b0;
    host_valid = 1'b0;
    host_cmd   = 4'd0;
    host_op1   = 32'd0;
    host_op2   = 32'd0;
    in_resp    = 2'd0;
    in_data    = 32'd0;
    res_ready  = 1'b0;
    tick();
    tick();
    chk("rst_host_ready", host_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_bus", {req_cmd_out, req_data_out}, 36'd0);
    chk("rst_res", {res_resp, res_data, res_timeout}, 35'd0);
    chk("rst_stray", stray_resp, 1'b0);
    chk("rst_txn", txn_count, 8'd0);
    reset = 1'b1;
    tick();
    chk("idle_host_ready", host_ready, 1'b1);

    // SHL with OK response, then result held for 5 cycles while host offers again.
    send(CMD_SHL, 32'h1FFF_FFFF, 32'd3);
    respond(RESP_OK, 32'hFFFF_FFF8);
    chk("shl_valid", res_valid, 1'b1);
    chk("shl_resp", res_resp, RESP_OK);
    chk("shl_data", res_data, 32'hFFFF_FFF8);
    chk("shl_timeout", res_timeout, 1'b0);
    chk("shl_txn_before_ack", txn_count, 8'd0);
    host_valid = 1'b1;
    host_cmd   = CMD_ADD;
    host_op1   = 32'd7;
    host_op2   = 32'd8;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_data", res_data, 32'hFFFF_FFF8);
      chk("hold_resp", res_resp, RESP_OK);
      chk("hold_host_ready", host_ready, 1'b0);
      chk("hold_bus", req_cmd_out, 4'd0);
    end
    ack(8'd1);
    chk("no_early_accept", req_cmd_out, 4'd0);
    send(CMD_ADD, 32'd7, 32'd8);
    respond(RESP_OK, 32'd15);
    chk("add_data", res_data, 32'd15);
    ack(8'd2);

    // SUB returning ERR is passed through.
    send(CMD_SUB, 32'h0008_0000, 32'h0010_0000);
    respond(RESP_ERR, 32'hDEAD_0001);
    chk("sub_valid", res_valid, 1'b1);
    chk("sub_resp", res_resp, RESP_ERR);
    chk("sub_data", res_data, 32'hDEAD_0001);
    chk("sub_timeout", res_timeout, 1'b0);
    ack(8'd3);

    // No response: timeout after exactly 10 WAIT cycles.
    send(CMD_ADD, 32'd1, 32'd2);
    n = 0;
    while (res_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 10);
    chk("to_flag", res_timeout, 1'b1);
    chk("to_resp", res_resp, 2'd0);
    chk("to_data", res_data, 32'd0);
    ack(8'd4);

    // NOP command: calc1 untouched, result one cycle after accept.
    host_valid = 1'b1;
    host_cmd   = CMD_NOP;
    host_op1   = 32'hAAAA_AAAA;
    host_op2   = 32'h5555_5555;
    tick();
    host_valid = 1'b0;
    chk("nop_bus", {req_cmd_out, req_data_out}, 36'd0);
    chk("nop_valid", res_valid, 1'b1);
    chk("nop_resp", res_resp, RESP_ERR);
    chk("nop_timeout", res_timeout, 1'b0);
    ack(8'd5);

    // res_ready in IDLE is ignored.
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_ready_txn", txn_count, 8'd5);
    chk("idle_ready_valid", res_valid, 1'b0);

    // Response in the final WAIT cycle beats the timeout.
    send(CMD_SHR, 32'h100, 32'd4);
    for (int i = 0; i < 9; i++) tick();
    chk("prio_not_done", res_valid, 1'b0);
    respond(RESP_OK, 32'h10);
    chk("prio_timeout", res_timeout, 1'b0);
    chk("prio_resp", res_resp, RESP_OK);
    chk("prio_data", res_data, 32'h10);
    ack(8'd6);
    chk("no_stray_yet", stray_resp, 1'b0);

    // Reset during WAIT, then a late response arrives in IDLE.
    send(CMD_SHR, 32'h80, 32'd4);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_host_ready", host_ready, 1'b0);
    chk("mid_rst_valid", res_valid, 1'b0);
    chk("mid_rst_txn", txn_count, 8'd0);
    chk("mid_rst_bus", {req_cmd_out, req_data_out}, 36'd0);
    reset = 1'b1;
    respond(RESP_OK, 32'h1234);
    chk("stray_set", stray_resp, 1'b1);
    chk("stray_not_captured", {res_valid, res_resp, res_data}, 35'd0);
    chk("post_rst_host_ready", host_ready, 1'b1);
    tick();
    chk("stray_sticky", stray_resp, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
